// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI slave with burst read/write access to a register file, plus a concurrent host port
module spi_regfile_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int NUM_REGS = 50,
  parameter bit CPOL = 1'b1,
  parameter bit CPHA = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_err
);
  localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CW = $clog2(SW + 1);
  localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_q, cs_q;
  logic [SW-1:0] shreg, shreg_in;
  logic [CW-1:0] bit_cnt;
  logic [ADDR_W-1:0] addr, cmd_addr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] spi_wd;
  logic sck_s, cs_s, mosi_s, lead, trail, sample, shift, cmd_done, word_done, spi_we;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NR;
  endfunction

  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // Mux over implemented registers only, so out-of-range addresses read as zero
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) if (a == ADDR_W'(i)) r = regs[i];
    return r;
  endfunction

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign busy = ~cs_s;
  assign lead = (sck_s != sck_q) && (sck_q == CPOL);
  assign trail = (sck_s != sck_q) && (sck_s == CPOL);
  assign sample = CPHA ? trail : lead;
  assign shift = CPHA ? lead : trail;
  assign shreg_in = {shreg[SW-2:0], mosi_s};
  assign cmd_addr = shreg[ADDR_W-1:0];
  assign cmd_done = bit_cnt == CW'(ADDR_W);
  assign word_done = bit_cnt == CW'(DATA_W - 1);
  assign spi_wd = {shreg[DATA_W-2:0], mosi_s};

  always_comb begin
    state_nx = state;
    spi_we = 1'b0;
    if (state == IDLE) state_nx = (!cs_s && cs_q) ? CMD : IDLE;
    else if (cs_s) state_nx = IDLE;
    else if (state == CMD && sample && cmd_done) state_nx = mosi_s ? READ : WRITE;
    else if (state == WRITE && sample && word_done) spi_we = in_range(addr);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_sync <= {SYNC_STAGES{CPOL}};
      cs_sync <= '1;
      mosi_sync <= '0;
      sck_q <= CPOL;
      cs_q <= 1'b1;
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      addr <= '0;
      miso <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_err <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_q <= sck_s;
      cs_q <= cs_s;
      state <= state_nx;
      wr_strobe <= spi_we;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= spi_wd;
      end
      frame_err <= cs_s && (state == CMD || state == WRITE) && bit_cnt != '0;
      if (state == IDLE || cs_s) begin
        bit_cnt <= '0;
        miso <= 1'b0;
      end else if (state == CMD) begin
        if (sample && cmd_done) begin
          bit_cnt <= '0;
          addr <= mosi_s ? adv(cmd_addr) : cmd_addr;
          if (mosi_s) shreg <= SW'(rd(cmd_addr));
        end else if (sample) begin
          shreg <= shreg_in;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == READ) begin
        if (shift) begin
          miso <= shreg[DATA_W-1];
          if (word_done) begin
            shreg <= SW'(rd(addr));
            addr <= adv(addr);
            bit_cnt <= '0;
          end else begin
            shreg <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else if (sample) begin
        if (word_done) begin
          addr <= adv(addr);
          bit_cnt <= '0;
        end else begin
          shreg <= shreg_in;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end

  // SPI write has priority over the host when both target the same register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      host_rd_data <= '0;
    end else begin
      host_rd_data <= rd(host_addr);
      for (int i = 0; i < NUM_REGS; i++)
        if (spi_we && addr == ADDR_W'(i)) regs[i] <= spi_wd;
        else if (host_wr_en && host_addr == ADDR_W'(i)) regs[i] <= host_wr_data;
    end
endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb_spi_regfile_slave: directed vectors for the SPI register-file slave in modes 3 and 0
module tb_spi_regfile_slave;
  localparam int HALF = 80;
  typedef struct {
    logic       we;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } hvec_t;
  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } svec_t;
  hvec_t hv [8];
  svec_t sv [4];
  logic clk = 1'b0, rst = 1'b1;
  logic sck3 = 1'b1, cs3_n = 1'b1, sck0 = 1'b0, cs0_n = 1'b1, mosi = 1'b0;
  logic miso3, miso0, busy3, busy0, ws3, ws0, fe3, fe0;
  logic [6:0] ha = '0, wa3, wa0, la;
  logic hwe = 1'b0;
  logic [7:0] hwd = '0, hrd3, hrd0, wd3, wd0, ld, r, r1, r2, v;
  logic b, seen;
  int total = 0, bad = 0, ns3 = 0, ns0 = 0, nfe3 = 0, s;

  always #5 clk = ~clk;

  spi_regfile_slave u3 (
    .clk(clk), .rst(rst), .sck(sck3), .cs_n(cs3_n), .mosi(mosi), .miso(miso3),
    .host_addr(ha), .host_wr_en(hwe), .host_wr_data(hwd), .host_rd_data(hrd3),
    .wr_strobe(ws3), .wr_addr(wa3), .wr_data(wd3), .busy(busy3), .frame_err(fe3)
  );

  spi_regfile_slave #(.CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst(rst), .sck(sck0), .cs_n(cs0_n), .mosi(mosi), .miso(miso0),
    .host_addr(7'h00), .host_wr_en(1'b0), .host_wr_data(8'h00), .host_rd_data(hrd0),
    .wr_strobe(ws0), .wr_addr(wa0), .wr_data(wd0), .busy(busy0), .frame_err(fe0)
  );

  always @(negedge clk) begin
    if (ws3) begin
      ns3++;
      la = wa3;
      ld = wd3;
    end
    if (ws0) ns0++;
    if (fe3) nfe3++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bitx(input bit m0, input logic bo, output logic bi);
    if (!m0) begin
      sck3 = 1'b0;
      mosi = bo;
      #HALF;
      bi = miso3;
      sck3 = 1'b1;
      #HALF;
    end else begin
      mosi = bo;
      #HALF;
      bi = miso0;
      sck0 = 1'b1;
      #HALF;
      sck0 = 1'b0;
    end
  endtask

  task automatic word(input bit m0, input logic [7:0] wv, output logic [7:0] rv);
    logic bb;
    rv = '0;
    for (int i = 7; i >= 0; i--) begin
      bitx(m0, wv[i], bb);
      rv[i] = bb;
    end
  endtask

  task automatic start(input bit m0);
    if (m0) cs0_n = 1'b0;
    else cs3_n = 1'b0;
    #HALF;
  endtask

  task automatic stop(input bit m0);
    #HALF;
    if (m0) cs0_n = 1'b1;
    else cs3_n = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic spi_write(input bit m0, input logic [6:0] a, input logic [7:0] d);
    logic [7:0] x;
    start(m0);
    word(m0, {a, 1'b0}, x);
    word(m0, d, x);
    stop(m0);
  endtask

  task automatic spi_read(input bit m0, input logic [6:0] a, output logic [7:0] d);
    logic [7:0] x;
    start(m0);
    word(m0, {a, 1'b1}, x);
    word(m0, 8'h00, d);
    stop(m0);
  endtask

  task automatic host_read(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    ha = a;
    @(negedge clk);
    @(negedge clk);
    d = hrd3;
  endtask

  initial begin
    hv[0] = '{1'b1, 7'd6, 8'h6E, 8'h00};
    hv[1] = '{1'b0, 7'd6, 8'h00, 8'h6E};
    hv[2] = '{1'b1, 7'd7, 8'h7F, 8'h00};
    hv[3] = '{1'b0, 7'd7, 8'h00, 8'h7F};
    hv[4] = '{1'b1, 7'd2, 8'h2B, 8'h00};
    hv[5] = '{1'b0, 7'd2, 8'h00, 8'h2B};
    hv[6] = '{1'b1, 7'd80, 8'hEE, 8'h00};
    hv[7] = '{1'b0, 7'd80, 8'h00, 8'h00};
    sv[0] = '{7'h0A, 8'h81};
    sv[1] = '{7'h00, 8'hFF};
    sv[2] = '{7'h2F, 8'h5A};
    sv[3] = '{7'h31, 8'h96};
    repeat (4) @(posedge clk);
    #1;
    chk("rst_miso", miso3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_strobe", ws3, 0);
    chk("rst_ferr", fe3, 0);
    chk("rst_hrd", hrd3, 0);
    chk("rst_waddr", wa3, 0);
    chk("rst_wdata", wd3, 0);
    chk("rst_m0_outs", {miso0, busy0, ws0, fe0, hrd0, wa0, wd0}, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ha = hv[i].a;
      hwe = hv[i].we;
      hwd = hv[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("host_vec%0d", i), hrd3, hv[i].exp);
    end
    @(negedge clk) hwe = 1'b0;
    s = ns3;
    start(0);
    #1;
    chk("busy_in_frame", busy3, 1);
    word(0, 8'h0A, r);
    word(0, 8'hA5, r);
    stop(0);
    chk("wr5_strobes", ns3 - s, 1);
    chk("wr5_addr", la, 7'h05);
    chk("wr5_data", ld, 8'hA5);
    host_read(7'h05, r);
    chk("wr5_host", r, 8'hA5);
    start(0);
    word(0, 8'h0B, r);
    word(0, 8'h00, r);
    word(0, 8'h00, r1);
    word(0, 8'h00, r2);
    stop(0);
    chk("burst_rd0", r, 8'hA5);
    chk("burst_rd1", r1, 8'h6E);
    chk("burst_rd2", r2, 8'h7F);
    s = ns3;
    start(0);
    word(0, 8'h62, r);
    word(0, 8'h11, r);
    word(0, 8'h22, r);
    stop(0);
    chk("wrap_strobes", ns3 - s, 2);
    host_read(7'd49, r);
    chk("wrap_r49", r, 8'h11);
    host_read(7'd0, r);
    chk("wrap_r0", r, 8'h22);
    for (int i = 0; i < 4; i++) begin
      s = ns3;
      spi_write(0, sv[i].a, sv[i].d);
      chk($sformatf("vec%0d_strobes", i), ns3 - s, 1);
      chk($sformatf("vec%0d_waddr", i), la, sv[i].a);
      chk($sformatf("vec%0d_wdata", i), ld, sv[i].d);
      spi_read(0, sv[i].a, r);
      chk($sformatf("vec%0d_rd", i), r, sv[i].d);
    end
    spi_read(1, 7'h60, r);
    chk("m0_oor_rd", r, 8'h00);
    s = ns0;
    spi_write(1, 7'h60, 8'hFF);
    chk("m0_oor_wr", ns0 - s, 0);
    spi_write(1, 7'h03, 8'h3A);
    chk("m0_wr_strobe", ns0 - s, 1);
    chk("m0_wr_fields", {wa0, wd0}, {7'h03, 8'h3A});
    spi_read(1, 7'h03, r);
    chk("m0_rd", r, 8'h3A);
    s = ns3;
    start(0);
    word(0, 8'h04, r);
    for (int i = 0; i < 5; i++) bitx(0, 1'b1, b);
    stop(0);
    chk("ferr_count", nfe3, 1);
    chk("ferr_nostrobe", ns3 - s, 0);
    host_read(7'd2, r);
    chk("ferr_r2", r, 8'h2B);
    v = 8'h3C;
    start(0);
    word(0, 8'h08, r);
    for (int i = 7; i >= 1; i--) bitx(0, v[i], b);
    @(negedge clk);
    ha = 7'd4;
    hwd = 8'hC3;
    hwe = 1'b1;
    seen = 1'b0;
    fork
      bitx(0, v[0], b);
      begin
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          if (ws3) seen = 1'b1;
        end
        hwe = 1'b0;
      end
    join
    stop(0);
    chk("coll_seen", seen, 1);
    chk("coll_wdata", ld, 8'h3C);
    host_read(7'd4, r);
    chk("coll_r4", r, 8'h3C);
    start(0);
    word(0, 8'h0B, r);
    for (int i = 0; i < 3; i++) bitx(0, 1'b0, b);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_miso", miso3, 0);
    chk("midrst_busy", busy3, 0);
    cs3_n = 1'b1;
    sck3 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    host_read(7'd5, r);
    chk("midrst_r5", r, 8'h00);
    host_read(7'd49, r);
    chk("midrst_r49", r, 8'h00);
    s = ns3;
    spi_write(0, 7'h05, 8'h5A);
    chk("post_strobe", ns3 - s, 1);
    chk("post_wfields", {la, ld}, {7'h05, 8'h5A});
    spi_read(0, 7'h05, r);
    chk("post_rd", r, 8'h5A);
    chk("ferr_total", nfe3, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
